// File: rtl/mem_access_ctrl_if.sv
// Handshake bundle between the control unit / memory and the MAR/MDR sequencer.
interface mem_access_ctrl_if;
  logic rd_req;
  logic wr_req;
  logic mem_ack;
  logic MARin;
  logic MDRin;
  logic read;
  logic mem_rd;
  logic mem_wr;
  logic busy;
  logic done;
  logic err;

  // Requester/memory side: drives requests and ack, observes strobes and status
  modport master (
    output rd_req, wr_req, mem_ack,
    input  MARin, MDRin, read, mem_rd, mem_wr, busy, done, err
  );

  // Sequencer side
  modport slave (
    input  rd_req, wr_req, mem_ack,
    output MARin, MDRin, read, mem_rd, mem_wr, busy, done, err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MAR/MDR memory access sequencer: one read or write in flight, Moore outputs,
// bounded wait for the memory ack with a timeout abort.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic             clk,
  input  logic             clr,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_MAR,
    S_RD_WAIT,
    S_RD_LATCH,
    S_WR_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_nxt;
  op_t              r_op;
  op_t              w_op_nxt;
  logic             w_cnt_last;

  logic w_marin;
  logic w_mdrin;
  logic w_read;
  logic w_mem_rd;
  logic w_mem_wr;
  logic w_busy;
  logic w_done;
  logic w_err;

  assign w_cnt_last = (r_wait_cnt == CNT_LAST);

  // State, wait counter and operation registers; clr abandons any access
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_op       <= OP_RD;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_op       <= w_op_nxt;
    end
  end

  // Next-state logic; ack wins over timeout in the last allowed wait cycle
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_op_nxt       = r_op;
    case (r_state)
      S_IDLE: begin
        if (bus.rd_req) begin
          w_state_nxt = S_LD_MAR;
          w_op_nxt    = OP_RD;
        end else if (bus.wr_req) begin
          w_state_nxt = S_LD_MAR;
          w_op_nxt    = OP_WR;
        end
      end
      S_LD_MAR: begin
        w_wait_cnt_nxt = '0;
        w_state_nxt    = (r_op == OP_RD) ? S_RD_WAIT : S_WR_WAIT;
      end
      S_RD_WAIT: begin
        if (bus.mem_ack)      w_state_nxt = S_RD_LATCH;
        else if (w_cnt_last)  w_state_nxt = S_ERR;
        else                  w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
      end
      S_RD_LATCH: w_state_nxt = S_DONE;
      S_WR_WAIT: begin
        if (bus.mem_ack)      w_state_nxt = S_DONE;
        else if (w_cnt_last)  w_state_nxt = S_ERR;
        else                  w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the registered state only
  always_comb begin
    w_marin  = 1'b0;
    w_mdrin  = 1'b0;
    w_read   = 1'b0;
    w_mem_rd = 1'b0;
    w_mem_wr = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      S_IDLE: ;
      S_LD_MAR: begin
        w_marin = 1'b1;
        w_busy  = 1'b1;
      end
      S_RD_WAIT: begin
        w_mem_rd = 1'b1;
        w_read   = 1'b1;
        w_busy   = 1'b1;
      end
      S_RD_LATCH: begin
        w_mem_rd = 1'b1;
        w_read   = 1'b1;
        w_mdrin  = 1'b1;
        w_busy   = 1'b1;
      end
      S_WR_WAIT: begin
        w_mem_wr = 1'b1;
        w_busy   = 1'b1;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_busy = 1'b1;
      end
      S_ERR: begin
        w_err  = 1'b1;
        w_busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.MARin  = w_marin;
  assign bus.MDRin  = w_mdrin;
  assign bus.read   = w_read;
  assign bus.mem_rd = w_mem_rd;
  assign bus.mem_wr = w_mem_wr;
  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.err    = w_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: table of per-cycle vectors plus
// hand-written reset and timeout sequences.
module tb_mem_access_ctrl;

  logic clk;
  logic clr;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: {MARin, MDRin, read, mem_rd, mem_wr, busy, done, err}
  localparam logic [7:0] O_IDLE = 8'b0000_0000;
  localparam logic [7:0] O_LDM  = 8'b1000_0100;
  localparam logic [7:0] O_RDW  = 8'b0011_0100;
  localparam logic [7:0] O_RDL  = 8'b0111_0100;
  localparam logic [7:0] O_WRW  = 8'b0000_1100;
  localparam logic [7:0] O_DN   = 8'b0000_0110;
  localparam logic [7:0] O_ER   = 8'b0000_0101;

  logic [7:0] outs;
  assign outs = {bus.MARin, bus.MDRin, bus.read, bus.mem_rd,
                 bus.mem_wr, bus.busy, bus.done, bus.err};

  typedef struct {
    string      name;
    logic       rd;
    logic       wr;
    logic       ack;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic void add(string n, logic rd, logic wr, logic ack, logic [7:0] e);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.ack = ack; v.exp = e;
    vecs.push_back(v);
  endfunction

  // Inputs change on the falling edge; outputs sampled 1 time unit after the rising edge
  task automatic step(input logic rd, input logic wr, input logic ack);
    @(negedge clk);
    bus.rd_req  = rd;
    bus.wr_req  = wr;
    bus.mem_ack = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    n_cmp++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, outs, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int rd_cycles;
    int err_cyc;
    int done_seen;
    int mdr_seen;

    // Read, ack on the 3rd wait cycle
    add("rd_marin",   1, 0, 0, O_LDM);
    add("rd_wait1",   0, 0, 0, O_RDW);
    add("rd_wait2",   0, 0, 0, O_RDW);
    add("rd_wait3",   0, 0, 0, O_RDW);
    add("rd_latch",   0, 0, 1, O_RDL);
    add("rd_done",    0, 0, 0, O_DN);
    add("rd_idle",    0, 0, 0, O_IDLE);
    // Write, ack on the 1st wait cycle
    add("wr_marin",   0, 1, 0, O_LDM);
    add("wr_wait1",   0, 0, 0, O_WRW);
    add("wr_done",    0, 0, 1, O_DN);
    add("wr_idle",    0, 0, 0, O_IDLE);
    // Simultaneous requests pick read; held wr_req ignored until IDLE
    add("both_marin", 1, 1, 0, O_LDM);
    add("both_rdw",   0, 1, 0, O_RDW);
    add("both_rdl",   0, 1, 1, O_RDL);
    add("both_done",  0, 1, 0, O_DN);
    add("both_idle",  0, 1, 0, O_IDLE);
    add("late_wr",    0, 1, 0, O_LDM);
    add("late_wrw",   0, 0, 0, O_WRW);
    add("late_done",  0, 0, 1, O_DN);
    add("late_idle",  0, 0, 0, O_IDLE);
    // Stray acks outside wait states; back-to-back reads with rd_req held
    add("stray_idle", 0, 0, 1, O_IDLE);
    add("b2b_marin1", 1, 0, 1, O_LDM);
    add("stray_ldm",  1, 0, 1, O_RDW);
    add("b2b_rdl1",   1, 0, 1, O_RDL);
    add("stray_rdl",  1, 0, 1, O_DN);
    add("stray_done", 1, 0, 1, O_IDLE);
    add("b2b_marin2", 1, 0, 0, O_LDM);
    add("b2b_rdw2",   0, 0, 0, O_RDW);
    add("b2b_rdl2",   0, 0, 1, O_RDL);
    add("b2b_done2",  0, 0, 0, O_DN);
    add("b2b_idle2",  0, 0, 0, O_IDLE);

    bus.rd_req  = 1'b0;
    bus.wr_req  = 1'b0;
    bus.mem_ack = 1'b0;
    clr = 1'b0;
    #23;
    check("reset_outs", O_IDLE);
    @(negedge clk);
    clr = 1'b1;
    step(0, 0, 0);
    check("post_reset_idle", O_IDLE);

    foreach (vecs[i]) begin
      step(vecs[i].rd, vecs[i].wr, vecs[i].ack);
      check(vecs[i].name, vecs[i].exp);
    end

    // Asynchronous reset in the middle of a read wait
    step(1, 0, 0);
    check("ar_marin", O_LDM);
    step(0, 0, 0);
    check("ar_rdw", O_RDW);
    #2;
    clr = 1'b0;
    #1;
    check("ar_async_clear", O_IDLE);
    @(negedge clk);
    clr = 1'b1;
    step(1, 0, 0);
    check("ar_marin_again", O_LDM);
    step(0, 0, 0);
    check("ar_rdw_again", O_RDW);
    step(0, 0, 1);
    check("ar_rdl", O_RDL);
    step(0, 0, 0);
    check("ar_done", O_DN);
    step(0, 0, 0);
    check("ar_idle", O_IDLE);

    // Read timeout with no ack: 16 wait cycles, err on cycle 18
    step(1, 0, 0);
    check("to_marin", O_LDM);
    rd_cycles = 0; err_cyc = -1; done_seen = 0; mdr_seen = 0;
    for (int c = 1; c <= 40 && err_cyc < 0; c++) begin
      step(0, 0, 0);
      if (bus.mem_rd) rd_cycles++;
      if (bus.done)   done_seen++;
      if (bus.MDRin)  mdr_seen++;
      if (bus.err)    err_cyc = c + 1;
    end
    check_int("to_mem_rd_cycles", rd_cycles, 16);
    check_int("to_err_cycle", err_cyc, 18);
    check_int("to_done_count", done_seen, 0);
    check_int("to_mdrin_count", mdr_seen, 0);
    step(0, 0, 0);
    check("to_idle", O_IDLE);

    // Ack in the 16th (last) wait cycle still succeeds
    step(1, 0, 0);
    check("lastack_marin", O_LDM);
    for (int k = 1; k <= 17; k++) begin
      step(0, 0, (k == 17));
      check((k == 17) ? "lastack_rdl" : "lastack_rdw", (k == 17) ? O_RDL : O_RDW);
    end
    step(0, 0, 0);
    check("lastack_done", O_DN);
    step(0, 0, 0);
    check("lastack_idle", O_IDLE);

    // Write timeout: err after 16 write wait cycles
    step(0, 1, 0);
    check("wto_marin", O_LDM);
    for (int k = 1; k <= 16; k++) begin
      step(0, 0, 0);
      check("wto_wrw", O_WRW);
    end
    step(0, 0, 0);
    check("wto_err", O_ER);
    step(0, 0, 0);
    check("wto_idle", O_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
